pipeline_ctrl: RTL and testbench

- Sequences the 3-stage 8051 pipeline: fetch/IR, execute (Buffer 1), write-back (Buffer 2).
- Generates per-stage load enables and bubble (flush) controls.
- Flush source: taken branch (pc_load from the hazard unit).
- Stall source: external memory wait.
- Also handles post-reset refill and halt/resume.
- Sits between the hazard unit, the PC/IR registers, the two pipeline buffers and the memory interface.

---
 rtl/pipeline_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl : stage enables and bubbles for the 3-stage 8051 pipeline
// Optional perf counters: PIPE_CTRL_PERF_CNT_EN        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned FILL_CYCLES  = 2,
   parameter int unsigned MEM_TIMEOUT  = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pc_load,
   input  logic        i_mem_req,
   input  logic        i_mem_ready,
   input  logic        i_halt,
   input  logic        i_resume,
   output logic        o_pc_en,
   output logic        o_ir_en,
   output logic        o_ir_flush,
   output logic        o_buf1_en,
   output logic        o_buf1_flush,
   output logic        o_buf2_en,
   output logic [2:0]  o_state,
   output logic        o_timeout,
   output logic [15:0] o_stall_cnt,
   output logic [15:0] o_flush_cnt
);

   typedef enum logic [2:0] {
      ST_FILL  = 3'd0,
      ST_RUN   = 3'd1,
      ST_FLUSH = 3'd2,
      ST_STALL = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   localparam logic [7:0] FILL_LAST  = 8'(FILL_CYCLES - 1);
   localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);
   localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_FILL;
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
      o_pc_en      = 1'b0;
      o_ir_en      = 1'b0;
      o_ir_flush   = 1'b0;
      o_buf1_en    = 1'b0;
      o_buf1_flush = 1'b0;
      o_buf2_en    = 1'b0;

      case (state_q)
         ST_FILL: begin
            o_pc_en      = 1'b1;
            o_ir_en      = 1'b1;
            o_buf1_en    = 1'b1;
            o_buf1_flush = 1'b1;
            o_buf2_en    = 1'b1;
            if (cnt_q >= FILL_LAST) begin
               state_d = ST_RUN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_RUN: begin
            if (i_mem_req && !i_mem_ready) begin
               // A coincident branch is dropped: IR is held, so decode re-raises it.
               o_buf2_en = 1'b1;
               state_d   = ST_STALL;
               cnt_d     = 8'd0;
            end else if (i_halt) begin
               state_d = ST_HALT;
            end else if (i_pc_load) begin
               o_pc_en    = 1'b1;
               o_ir_en    = 1'b1;
               o_ir_flush = 1'b1;
               o_buf1_en  = 1'b1;
               o_buf2_en  = 1'b1;
               state_d    = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
               cnt_d      = 8'd1;
            end else begin
               o_pc_en   = 1'b1;
               o_ir_en   = 1'b1;
               o_buf1_en = 1'b1;
               o_buf2_en = 1'b1;
            end
         end

         ST_FLUSH: begin
            o_pc_en    = 1'b1;
            o_ir_en    = 1'b1;
            o_ir_flush = 1'b1;
            o_buf1_en  = 1'b1;
            o_buf2_en  = 1'b1;
            if (cnt_q >= FLUSH_LAST) begin
               state_d = ST_RUN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_STALL: begin
            o_buf2_en = (cnt_q == 8'd0);
            if (i_mem_ready) begin
               o_buf1_en = 1'b1;
               state_d   = ST_RUN;
               cnt_d     = 8'd0;
            end else if (cnt_q >= TMO_LAST) begin
               // Abort: the stalled instruction is replaced by a NOP in Buffer 1.
               timeout_d    = 1'b1;
               o_buf1_en    = 1'b1;
               o_buf1_flush = 1'b1;
               state_d      = ST_RUN;
               cnt_d        = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_HALT: begin
            if (i_resume) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_FILL;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign o_state   = state_q;
   assign o_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [15:0] stall_cnt_q, flush_cnt_q;
   logic        flush_evt;

   assign flush_evt = (state_q == ST_RUN) && i_pc_load && !i_halt
                      && !(i_mem_req && !i_mem_ready);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         if ((state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (flush_evt && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = 16'h0000;
   assign o_flush_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl : directed scoreboard bench for pipeline_ctrl  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst, pc_load, mem_req, mem_ready, halt, resume;
   logic        pc_en, ir_en, ir_flush, buf1_en, buf1_flush, buf2_en;
   logic [2:0]  state;
   logic        timeout;
   logic [15:0] stall_cnt, flush_cnt;

   int tests = 0;
   int fails = 0;
   int step_no = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .FLUSH_CYCLES (2),
      .FILL_CYCLES  (2),
      .MEM_TIMEOUT  (15)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pc_load    (pc_load),
      .i_mem_req    (mem_req),
      .i_mem_ready  (mem_ready),
      .i_halt       (halt),
      .i_resume     (resume),
      .o_pc_en      (pc_en),
      .o_ir_en      (ir_en),
      .o_ir_flush   (ir_flush),
      .o_buf1_en    (buf1_en),
      .o_buf1_flush (buf1_flush),
      .o_buf2_en    (buf2_en),
      .o_state      (state),
      .o_timeout    (timeout),
      .o_stall_cnt  (stall_cnt),
      .o_flush_cnt  (flush_cnt)
   );

   // input vector {rst, pc_load, mem_req, mem_ready, halt, resume}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_RST  = 6'b100000;
   localparam logic [5:0] I_PL   = 6'b010000;
   localparam logic [5:0] I_MRQ  = 6'b001000;
   localparam logic [5:0] I_RDY  = 6'b000100;
   localparam logic [5:0] I_HALT = 6'b000010;
   localparam logic [5:0] I_RES  = 6'b000001;

   // enable vector {pc_en, ir_en, ir_flush, buf1_en, buf1_flush, buf2_en}
   localparam logic [5:0] E_FILL  = 6'b110111;
   localparam logic [5:0] E_RUN   = 6'b110101;
   localparam logic [5:0] E_BR    = 6'b111101;
   localparam logic [5:0] E_DRAIN = 6'b000001;
   localparam logic [5:0] E_NONE  = 6'b000000;
   localparam logic [5:0] E_RDY   = 6'b000100;
   localparam logic [5:0] E_TMO   = 6'b000110;

   localparam logic [2:0] S_FILL = 3'd0, S_RUN = 3'd1, S_FLUSH = 3'd2,
                          S_STALL = 3'd3, S_HALT = 3'd4;

   typedef struct packed {
      logic [2:0] st;
      logic [5:0] en;
      logic       to;
   } exp_t;

   exp_t sb[$];

   task automatic step(input logic [5:0] in, input logic [2:0] st,
                       input logic [5:0] en, input logic to);
      exp_t e;
      logic [5:0] obs_en;
      {rst, pc_load, mem_req, mem_ready, halt, resume} = in;
      sb.push_back('{st: st, en: en, to: to});
      step_no++;
      @(negedge clk);
      e = sb.pop_front();
      obs_en = {pc_en, ir_en, ir_flush, buf1_en, buf1_flush, buf2_en};
      tests++;
      assert (state === e.st) else begin
         fails++;
         $error("FAIL state step %0d: observed %0d expected %0d", step_no, state, e.st);
      end
      tests++;
      assert (obs_en === e.en) else begin
         fails++;
         $error("FAIL enables step %0d: observed %b expected %b", step_no, obs_en, e.en);
      end
      tests++;
      assert (timeout === e.to) else begin
         fails++;
         $error("FAIL timeout step %0d: observed %b expected %b", step_no, timeout, e.to);
      end
      @(posedge clk);
      #1;
   endtask

   // Expected values are the feature-on counts; the default build ties both to zero.
   task automatic chk_cnt(input logic [15:0] sc, input logic [15:0] fc);
      logic [15:0] exp_sc, exp_fc;
`ifdef PIPE_CTRL_PERF_CNT_EN
      exp_sc = sc;
      exp_fc = fc;
`else
      exp_sc = 16'h0000 & sc;
      exp_fc = 16'h0000 & fc;
`endif
      tests++;
      assert (stall_cnt === exp_sc) else begin
         fails++;
         $error("FAIL stall_cnt after step %0d: observed %0d expected %0d", step_no, stall_cnt, exp_sc);
      end
      tests++;
      assert (flush_cnt === exp_fc) else begin
         fails++;
         $error("FAIL flush_cnt after step %0d: observed %0d expected %0d", step_no, flush_cnt, exp_fc);
      end
   endtask

   initial begin
      {rst, pc_load, mem_req, mem_ready, halt, resume} = I_RST;
      @(posedge clk);
      #1;
      step(I_RST, S_FILL, E_FILL, 1'b0);
      step(I_RST, S_FILL, E_FILL, 1'b0);
      chk_cnt(16'd0, 16'd0);

      // post-reset refill: two bubble cycles, then RUN
      step(I_NONE, S_FILL, E_FILL, 1'b0);
      step(I_NONE, S_FILL, E_FILL, 1'b0);
      step(I_NONE, S_RUN,  E_RUN,  1'b0);

      // taken branch; second pc_load during FLUSH is ignored
      step(I_PL,   S_RUN,   E_BR,  1'b0);
      step(I_PL,   S_FLUSH, E_BR,  1'b0);
      step(I_NONE, S_RUN,   E_RUN, 1'b0);
      chk_cnt(16'd0, 16'd1);

      // memory wait, ready in the fourth STALL cycle
      step(I_MRQ,         S_RUN,   E_DRAIN, 1'b0);
      step(I_MRQ,         S_STALL, E_DRAIN, 1'b0);
      step(I_MRQ,         S_STALL, E_NONE,  1'b0);
      step(I_MRQ,         S_STALL, E_NONE,  1'b0);
      step(I_MRQ | I_RDY, S_STALL, E_RDY,   1'b0);
      step(I_NONE,        S_RUN,   E_RUN,   1'b0);
      chk_cnt(16'd4, 16'd1);

      // memory never ready: abort after 15 STALL cycles
      step(I_MRQ, S_RUN,   E_DRAIN, 1'b0);
      step(I_MRQ, S_STALL, E_DRAIN, 1'b0);
      for (int i = 0; i < 13; i++) step(I_MRQ, S_STALL, E_NONE, 1'b0);
      step(I_MRQ,  S_STALL, E_TMO, 1'b0);
      step(I_NONE, S_RUN,   E_RUN, 1'b1);
      chk_cnt(16'd19, 16'd1);

      // stall beats halt and branch; halt then taken after ready
      step(I_MRQ | I_PL | I_HALT,         S_RUN,   E_DRAIN, 1'b1);
      step(I_MRQ | I_PL | I_HALT,         S_STALL, E_DRAIN, 1'b1);
      step(I_MRQ | I_RDY | I_PL | I_HALT, S_STALL, E_RDY,   1'b1);
      step(I_PL | I_HALT,                 S_RUN,   E_NONE,  1'b1);
      step(I_HALT,                        S_HALT,  E_NONE,  1'b1);
      step(I_HALT | I_RES,                S_HALT,  E_NONE,  1'b1);
      step(I_HALT,                        S_RUN,   E_NONE,  1'b1);
      step(I_RES,                         S_HALT,  E_NONE,  1'b1);
      step(I_NONE,                        S_RUN,   E_RUN,   1'b1);
      chk_cnt(16'd21, 16'd1);

      // reset in STALL cycle 3 clears state, timeout and counters
      step(I_MRQ,         S_RUN,   E_DRAIN, 1'b1);
      step(I_MRQ,         S_STALL, E_DRAIN, 1'b1);
      step(I_MRQ,         S_STALL, E_NONE,  1'b1);
      step(I_MRQ | I_RST, S_STALL, E_NONE,  1'b1);
      chk_cnt(16'd0, 16'd0);
      step(I_NONE, S_FILL, E_FILL, 1'b0);
      step(I_NONE, S_FILL, E_FILL, 1'b0);
      step(I_NONE, S_RUN,  E_RUN,  1'b0);

      // ready on the timeout cycle wins: no abort, no timeout flag
      step(I_MRQ, S_RUN,   E_DRAIN, 1'b0);
      step(I_MRQ, S_STALL, E_DRAIN, 1'b0);
      for (int i = 0; i < 13; i++) step(I_MRQ, S_STALL, E_NONE, 1'b0);
      step(I_MRQ | I_RDY, S_STALL, E_RDY, 1'b0);
      step(I_NONE,        S_RUN,   E_RUN, 1'b0);
      chk_cnt(16'd15, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
